// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// immediate/next-PC/write-back select codes and the base-ISA opcode constants.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_LUI    = 4'd6,
    CL_AUIPC  = 4'd7,
    CL_JAL    = 4'd8,
    CL_JALR   = 4'd9
  } cls_e;

  // Must track the immediate generator's op encoding.
  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic [1:0] NPC_PLUS4 = 2'd0;
  localparam logic [1:0] NPC_BR    = 2'd1;
  localparam logic [1:0] NPC_JAL   = 2'd2;
  localparam logic [1:0] NPC_JALR  = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_SEXT = 2'd3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] sext_op;
    logic [1:0] wb_sel;
    logic [1:0] npc_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: purely combinational map from inst[6:0] to class and datapath selects.
// Zero latency, no handshake; unknown opcodes raise illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] cls,
  output logic [2:0] sext_op,
  output logic [1:0] wb_sel,
  output logic [1:0] npc_op,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       illegal
);

  always_comb begin
    cls       = CL_NONE;
    sext_op   = SEXT_I;
    wb_sel    = WB_ALU;
    npc_op    = NPC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: cls = CL_R;
      OP_IALU: begin
        cls       = CL_I;
        alu_b_sel = 1'b1;
      end
      OP_LOAD: begin
        cls       = CL_LOAD;
        alu_b_sel = 1'b1;
        wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        cls       = CL_STORE;
        sext_op   = SEXT_S;
        alu_b_sel = 1'b1;
      end
      OP_BRANCH: begin
        cls       = CL_BRANCH;
        sext_op   = SEXT_B;
        alu_a_sel = 1'b1;
      end
      OP_LUI: begin
        cls       = CL_LUI;
        sext_op   = SEXT_U;
        alu_b_sel = 1'b1;
        wb_sel    = WB_SEXT;
      end
      OP_AUIPC: begin
        cls       = CL_AUIPC;
        sext_op   = SEXT_U;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end
      OP_JAL: begin
        cls       = CL_JAL;
        sext_op   = SEXT_J;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        wb_sel    = WB_PC4;
        npc_op    = NPC_JAL;
      end
      OP_JALR: begin
        cls       = CL_JALR;
        alu_b_sel = 1'b1;
        wb_sel    = WB_PC4;
        npc_op    = NPC_JALR;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction at zero wait.
// Memory requests hold until ack; an ack missing for WAIT_MAX+1 cycles traps until reset.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] inst,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic [2:0]  sext_op,
  output logic [1:0]  npc_op,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        trap,
  output logic [2:0]  state
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

  state_e        state_q, state_d;
  dec_t          dec_q, dec_d, dec_now, dec_sel;
  logic [CW-1:0] wait_q, wait_d;
  logic          trap_q, trap_d;
  logic          dec_illegal;
  logic          unused_inst;

  assign unused_inst = ^inst[31:7];

  ctrl_decode u_decode (
    .opcode    (inst[6:0]),
    .cls       (dec_now.cls),
    .sext_op   (dec_now.sext_op),
    .wb_sel    (dec_now.wb_sel),
    .npc_op    (dec_now.npc_op),
    .alu_a_sel (dec_now.alu_a_sel),
    .alu_b_sel (dec_now.alu_b_sel),
    .illegal   (dec_illegal)
  );

  // DECODE still shows the live decode; later phases use the registered copy.
  assign dec_sel = (state_q == ST_DECODE) ? dec_now : dec_q;

  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    sext_op   = SEXT_I;
    npc_op    = NPC_PLUS4;
    wb_sel    = WB_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    trap      = trap_q;
    state     = state_q;

    if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      sext_op   = dec_sel.sext_op;
      alu_a_sel = dec_sel.alu_a_sel;
      alu_b_sel = dec_sel.alu_b_sel;
    end

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        dec_d   = dec_now;
        state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_q.cls == CL_BRANCH) begin
          pc_we   = 1'b1;
          npc_op  = br_taken ? NPC_BR : NPC_PLUS4;
          state_d = ST_FETCH;
        end else if (dec_q.cls == CL_LOAD || dec_q.cls == CL_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (dec_q.cls == CL_STORE);
        if (dmem_ack) begin
          if (dec_q.cls == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        npc_op  = dec_q.npc_op;
        wb_sel  = dec_q.wb_sel;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    // Reset silences everything in the same cycle so an in-flight instruction cannot retire.
    if (cpu_rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      sext_op   = 3'd0;
      npc_op    = 2'd0;
      wb_sel    = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      trap      = 1'b0;
      state     = 3'd0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)) begin
      wait_d = '0;
    end else if ((state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack)) begin
      wait_d = wait_q + 1'b1;
    end
    trap_d = trap_q | (state_d == ST_TRAP);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_FETCH;
      dec_q   <= '0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum extra wait cycles allowed for a memory ack before the block traps.
REQ-002 cpu_clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 cpu_rst  in  1  reset, synchronous and active-high.
REQ-004 inst  in  32  current instruction-register contents.
REQ-005 br_taken  in  1  branch-compare result from the ALU; valid in EXEC.
REQ-006 imem_req  out 1  instruction-fetch request; imem_ack  in  1  fetch data valid this cycle.
REQ-007 dmem_req  out 1  data-access request; dmem_we  out 1  store enable; dmem_ack  in  1  access complete this cycle.
REQ-008 pc_we, ir_we, rf_we  out  1 each  single-cycle write strobes for the PC, the IR and the register file.
REQ-009 sext_op  out 3  immediate-format select: I=0, S=1, B=2, U=3, J=4.
REQ-010 npc_op  out 2  next-PC source: PLUS4=0, BR=1, JAL=2, JALR=3.
REQ-011 wb_sel  out 2  write-back source: ALU=0, MEM=1, PC4=2, SEXT=3.
REQ-012 alu_a_sel, alu_b_sel  out 1 each  ALU operand select: 0 = rs1/rs2, 1 = PC/immediate.
REQ-013 trap  out 1  sticky fault flag; state  out 3  FSM state for debug.

Function
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=7.
REQ-015 FETCH SHALL hold imem_req=1 until imem_ack=1; in the ack cycle ir_we=1 for one cycle and the next state is DECODE.
REQ-016 DECODE SHALL classify inst[6:0] and register the result, which holds stable until the instruction retires:
- 0110011: R-type
- 0010011: I-ALU
- 0000011: load
- 0100011: store
- 1100011: branch
- 0110111: lui
- 0010111: auipc
- 1101111: jal
- 1100111: jalr
REQ-017 Any other opcode SHALL send DECODE to TRAP.
REQ-018 sext_op SHALL be I for I-ALU, load and jalr; S for store; B for branch; U for lui and auipc; J for jal; 0 for R-type.
REQ-019 sext_op SHALL be driven from DECODE through the last cycle of the instruction.
REQ-020 EXEC SHALL last exactly one cycle; the next state is:
- branch: FETCH, with pc_we=1 and npc_op=BR if br_taken else PLUS4
- load or store: MEM
- all others: WB
REQ-021 MEM SHALL hold dmem_req=1 (and dmem_we=1 for a store) until dmem_ack.
REQ-022 In the MEM ack cycle, a store SHALL pulse pc_we (PLUS4) and go to FETCH; a load SHALL go to WB.
REQ-023 WB SHALL pulse rf_we=1 and pc_we=1 for one cycle and then go to FETCH, with:
- npc_op = JAL for jal, JALR for jalr, PLUS4 otherwise
- wb_sel = MEM for load, PC4 for jal/jalr, SEXT for lui, ALU otherwise
REQ-024 alu_a_sel SHALL be 1 for auipc, branch and jal, and 0 otherwise.
REQ-025 alu_b_sel SHALL be 1 for every class except R-type and branch.
REQ-026 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the ack is absent.
REQ-027 If the ack is absent in the cycle where count==WAIT_MAX, the next state SHALL be TRAP, so the request is high WAIT_MAX+1 cycles.
REQ-028 An ack arriving in that same cycle SHALL be accepted normally.
REQ-029 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-030 TRAP SHALL be sticky until reset: trap=1 and every request and strobe held 0.
REQ-031 Each instruction SHALL produce exactly one pc_we pulse and at most one rf_we pulse.
REQ-032 Latency with zero-wait acks SHALL be: ALU/lui/auipc/jal/jalr 4 cycles; branch 3; store 4; load 5.
REQ-033 All outputs SHALL be decoded from the registered state, the registered instruction class, and the current-cycle ack and br_taken inputs.

Reset
REQ-034 While cpu_rst=1, every output SHALL be 0 and the state SHALL load FETCH at the clock edge.
REQ-035 Reset SHALL clear the wait counter, the decoded class and the trap flag.
REQ-036 Reset asserted in any state, including mid-MEM, SHALL abort the instruction with no rf_we or pc_we pulse.
REQ-037 imem_req SHALL be 1 in the first cycle after cpu_rst deasserts.

Structure
REQ-038 A shared package ctrl_pkg SHALL hold the state encodings, the SEXT_I..SEXT_J codes (identical to the existing immediate generator's op codes), the NPC_* and WB_* codes, and the opcode constants.
REQ-039 The combinational opcode decoder SHALL be a sub-module ctrl_decode that maps opcode to class, sext_op, wb_sel, operand selects and illegal.
REQ-040 The FSM, wait counter and trap flag SHALL live in multicycle_ctrl.

Verification
REQ-041 addi x1,x0,5 (0x00500093) with zero-wait acks -> state sequence 0,1,2,4; sext_op=0; alu_b_sel=1; rf_we and pc_we each high once in cycle 4.
REQ-042 sw (0x00112223) with dmem_ack delayed 3 cycles -> dmem_req and dmem_we high 4 cycles; sext_op=1; rf_we never asserted; pc_we in the ack cycle.
REQ-043 beq taken (0x00000463) with br_taken=1 -> sext_op=2; npc_op=1 with pc_we in EXEC; next FETCH in cycle 4.
REQ-044 inst=0xFFFFFFFF -> TRAP in the cycle after DECODE; trap stays 1 for 20 or more cycles with no strobes; cpu_rst pulse -> state 0 and imem_req=1.
REQ-045 imem_ack held 0 with WAIT_MAX=15 -> imem_req high exactly 16 cycles, then trap=1; the same test with ack in cycle 16 -> normal DECODE.
REQ-046 lw (0x00002083), cpu_rst asserted during MEM -> all outputs 0 the next cycle; no rf_we; FETCH after release.
